// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus burst engine.
package rtc_bus_pkg;

    // Bus sequencer states; one address and one data phase per element.
    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_PULSE,
        A_HOLD,
        D_SETUP,
        D_PULSE,
        D_HOLD,
        GAP,
        DONE
    } rtc_state_e;

    // RTC register map: time/date block followed by the chrono block.
    localparam logic [7:0] RTC_ADDR_SECONDS    = 8'h21;
    localparam logic [7:0] RTC_ADDR_MINUTES    = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOURS      = 8'h23;
    localparam logic [7:0] RTC_ADDR_DAY        = 8'h24;
    localparam logic [7:0] RTC_ADDR_MONTH      = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEAR       = 8'h26;
    localparam logic [7:0] RTC_ADDR_CHRONO_SEC = 8'h27;
    localparam logic [7:0] RTC_ADDR_CHRONO_MIN = 8'h28;
    localparam logic [7:0] RTC_ADDR_CHRONO_HR  = 8'h29;
    localparam logic [7:0] RTC_ADDR_STATUS     = 8'h2A;

    // Levels of the control pins while the bus is idle (all inactive-high).
    localparam logic IDLE_CS  = 1'b1;
    localparam logic IDLE_RD  = 1'b1;
    localparam logic IDLE_WR  = 1'b1;
    localparam logic IDLE_A_D = 1'b1;

    // Larger of two phase lengths; used to size the shared phase timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_bus_engine_if.sv
// Command, status and RTC pin bundle between the controller and the engine.
interface rtc_bus_engine_if #(
    parameter int DATA_W  = 8,
    parameter int BURST_W = 4
);
    logic               start;
    logic               wr_nrd;
    logic [DATA_W-1:0]  base_addr;
    logic [BURST_W-1:0] burst_len;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_data_req;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_valid;
    logic [BURST_W-1:0] elem_index;
    logic               busy;
    logic               done;
    logic               A_D;
    logic               CS;
    logic               RD;
    logic               WR;
    logic [DATA_W-1:0]  bus_out;
    logic               bus_oe;
    logic [DATA_W-1:0]  bus_in;

    // Controller side: issues commands, supplies write data and bus readback.
    modport master (
        output start, wr_nrd, base_addr, burst_len, wr_data, bus_in,
        input  wr_data_req, rd_data, rd_valid, elem_index, busy, done,
        input  A_D, CS, RD, WR, bus_out, bus_oe
    );

    // Engine side.
    modport slave (
        input  start, wr_nrd, base_addr, burst_len, wr_data, bus_in,
        output wr_data_req, rd_data, rd_valid, elem_index, busy, done,
        output A_D, CS, RD, WR, bus_out, bus_oe
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter with a zero flag, shared by every bus phase.
module rtc_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load on phase entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/rtc_bus_engine.sv
// Burst sequencer for the RTC multiplexed address/data bus. Every pin is a
// flop whose next value is decoded from the next state, so pins change
// together with the state and no input reaches a pin combinationally.
module rtc_bus_engine
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2,
    parameter int BURST_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    rtc_bus_engine_if.slave  bus
);
    localparam int T_MAX = max_int(max_int(T_SETUP, T_PULSE), max_int(T_HOLD, T_GAP));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

    rtc_state_e         state_q, state_d;
    logic               wr_nrd_q, wr_nrd_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] idx_q, idx_d;

    logic               cs_q, cs_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               a_d_q, a_d_d;
    logic               oe_q, oe_d;
    logic [DATA_W-1:0]  bus_out_q, bus_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               wr_data_req_q, wr_data_req_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_zero;

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next state, command latches and phase-timer reload.
    always_comb begin
        state_d  = state_q;
        wr_nrd_d = wr_nrd_q;
        len_d    = len_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (bus.start && !busy_q) begin
                    wr_nrd_d = bus.wr_nrd;
                    len_d    = bus.burst_len;
                    addr_d   = bus.base_addr;
                    idx_d    = '0;
                    state_d  = (bus.burst_len == '0) ? DONE : A_SETUP;
                end
            end
            A_SETUP: if (tmr_zero) state_d = A_PULSE;
            A_PULSE: if (tmr_zero) state_d = A_HOLD;
            A_HOLD:  if (tmr_zero) state_d = D_SETUP;
            D_SETUP: if (tmr_zero) state_d = D_PULSE;
            D_PULSE: if (tmr_zero) state_d = D_HOLD;
            D_HOLD: begin
                if (tmr_zero) begin
                    state_d = (idx_q == len_q - BURST_W'(1)) ? DONE : GAP;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    addr_d  = addr_q + DATA_W'(1);
                    idx_d   = idx_q + BURST_W'(1);
                    state_d = A_SETUP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every transition enters a new phase, so reload the timer there.
        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                A_SETUP, D_SETUP: tmr_val = LD_SETUP;
                A_PULSE, D_PULSE: tmr_val = LD_PULSE;
                A_HOLD,  D_HOLD:  tmr_val = LD_HOLD;
                GAP:              tmr_val = LD_GAP;
                default:          tmr_val = '0;
            endcase
        end
    end

    // Pin and status values for the state being entered.
    always_comb begin
        cs_d          = IDLE_CS;
        rd_d          = IDLE_RD;
        wr_d          = IDLE_WR;
        a_d_d         = IDLE_A_D;
        oe_d          = 1'b0;
        bus_out_d     = '0;
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        wr_data_req_d = (state_d == A_SETUP) && (state_q != A_SETUP) && wr_nrd_d;
        rd_valid_d    = (state_d == D_HOLD) && (state_q == D_PULSE) && !wr_nrd_d;
        rd_data_d     = rd_data_q;

        case (state_d)
            A_SETUP, A_PULSE, A_HOLD: begin
                cs_d      = 1'b0;
                a_d_d     = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = addr_d;
                // The RTC latches the address on WR for both directions.
                wr_d      = (state_d != A_PULSE);
            end
            D_SETUP, D_PULSE, D_HOLD: begin
                cs_d  = 1'b0;
                a_d_d = 1'b1;
                if (wr_nrd_d) begin
                    oe_d      = 1'b1;
                    // Capture write data once, as the data phase opens.
                    bus_out_d = (state_q == A_HOLD) ? bus.wr_data : bus_out_q;
                    wr_d      = (state_d != D_PULSE);
                end else begin
                    rd_d      = (state_d != D_PULSE);
                end
            end
            default: begin
                cs_d = IDLE_CS;
            end
        endcase

        // Readback is taken at the end of the last strobe-low cycle.
        if (rd_valid_d) begin
            rd_data_d = bus.bus_in;
        end
    end

    // State, command and pin registers; reset releases the bus at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_nrd_q      <= 1'b0;
            len_q         <= '0;
            addr_q        <= '0;
            idx_q         <= '0;
            cs_q          <= IDLE_CS;
            rd_q          <= IDLE_RD;
            wr_q          <= IDLE_WR;
            a_d_q         <= IDLE_A_D;
            oe_q          <= 1'b0;
            bus_out_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            wr_data_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_nrd_q      <= wr_nrd_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            idx_q         <= idx_d;
            cs_q          <= cs_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            a_d_q         <= a_d_d;
            oe_q          <= oe_d;
            bus_out_q     <= bus_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            wr_data_req_q <= wr_data_req_d;
        end
    end

    assign bus.CS          = cs_q;
    assign bus.RD          = rd_q;
    assign bus.WR          = wr_q;
    assign bus.A_D         = a_d_q;
    assign bus.bus_oe      = oe_q;
    assign bus.bus_out     = bus_out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wr_data_req = wr_data_req_q;
    assign bus.elem_index  = idx_q;
endmodule
